// File: rtl/vlsu_addr_gen.sv
// vlsu_addr_gen
//   Vector load/store address generator. Turns a base/stride/vl/vsew
//   configuration into a stream of bus-word requests on an OBI-style
//   req/gnt/rvalid port. It keeps up to MAX_OUTST beats in flight and tags
//   each in-order response with the element slice it carries.
//   There are two modes:
//     - unit-stride: elements are packed, and the base may be misaligned to the bus word.
//     - strided: one element per beat.
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   start_i                        start pulse; only sampled while idle
//   vsew_i, vl_i, strided_i,
//   stride_i, base_addr_i          transfer configuration, latched on start
//   data_req_o/data_gnt_i          bus request handshake
//   data_addr_o, data_be_o         word-aligned beat address and byte enables
//   data_rvalid_i                  in-order bus response
//   resp_idx_o/cnt_o/off_o         element slice of the responding beat
//   busy_o, done_o, err_o          status; done/err are single-cycle pulses
module vlsu_addr_gen #(
  parameter int ADDR_W    = 32,
  parameter int BUS_BYTES = 4,
  parameter int VL_W      = 5,
  parameter int MAX_OUTST = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [1:0]                   vsew_i,
  input  logic [VL_W-1:0]              vl_i,
  input  logic                         strided_i,
  input  logic [ADDR_W-1:0]            stride_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  output logic                         data_req_o,
  input  logic                         data_gnt_i,
  output logic [ADDR_W-1:0]            data_addr_o,
  output logic [BUS_BYTES-1:0]         data_be_o,
  input  logic                         data_rvalid_i,
  output logic [VL_W-1:0]              resp_idx_o,
  output logic [$clog2(BUS_BYTES):0]   resp_cnt_o,
  output logic [$clog2(BUS_BYTES)-1:0] resp_off_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int OFF_W = $clog2(BUS_BYTES);
  localparam int CNT_W = OFF_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state_q, state_d;

  // Control registers (reset)
  logic [OUT_W-1:0] outst_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             done_q, err_q;

  // Datapath registers (loaded on start, not reset)
  logic [ADDR_W-1:0]        cur_q;
  logic [VL_W-1:0]          idx_q, rem_q;
  logic [1:0]               sew_q;
  logic                     strided_q;
  logic signed [ADDR_W-1:0] stride_q;

  logic [VL_W-1:0]  fifo_idx [MAX_OUTST];
  logic [CNT_W-1:0] fifo_cnt [MAX_OUTST];
  logic [OFF_W-1:0] fifo_off [MAX_OUTST];

  logic [OFF_W-1:0]     off;
  logic [CNT_W-1:0]     room, cnt, nbytes;
  logic [BUS_BYTES-1:0] be;
  logic                 push, pop, last_beat, cfg_err, start_ok;

  function automatic logic [CNT_W-1:0] min_cnt(input logic [VL_W-1:0]  rem,
                                               input logic [CNT_W-1:0] lim);
    if ({{CNT_W{1'b0}}, rem} < {{VL_W{1'b0}}, lim}) return CNT_W'(rem);
    return lim;
  endfunction

  function automatic logic [BUS_BYTES-1:0] byte_mask(input logic [OFF_W-1:0] o,
                                                     input logic [CNT_W-1:0] n);
    logic [BUS_BYTES-1:0] m;
    m = '0;
    for (int b = 0; b < BUS_BYTES; b++)
      if (b >= int'(o) && b < int'(o) + int'(n)) m[b] = 1'b1;
    return m;
  endfunction

  // Only the low two address bits matter: the widest legal element is 4 bytes.
  function automatic logic misaligned(input logic [1:0] a, input logic [1:0] sew);
    case (sew)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTST - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign cfg_err  = (vsew_i == 2'd3) || misaligned(base_addr_i[1:0], vsew_i) ||
                    (strided_i && misaligned(stride_i[1:0], vsew_i));
  assign start_ok = (state_q == IDLE) && start_i && !cfg_err;

  // Beat formation from the current element pointer
  always_comb begin
    off       = cur_q[OFF_W-1:0];
    room      = (CNT_W'(BUS_BYTES) - {1'b0, off}) >> sew_q;
    cnt       = strided_q ? CNT_W'(1) : min_cnt(rem_q, room);
    nbytes    = cnt << sew_q;
    be        = byte_mask(off, nbytes);
    last_beat = (rem_q == VL_W'(cnt));
  end

  assign push = data_req_o && data_gnt_i;
  assign pop  = data_rvalid_i && (outst_q != '0);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok && vl_i != '0) state_d = ISSUE;
      ISSUE:   if (push && last_beat)      state_d = DRAIN;
      DRAIN:   if (outst_q == '0)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    data_req_o  = (state_q == ISSUE) && (outst_q < OUT_W'(MAX_OUTST));
    data_addr_o = '0;
    data_be_o   = '0;
    if (state_q == ISSUE) begin
      data_addr_o = {cur_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      data_be_o   = be;
    end
    busy_o = (state_q == ISSUE) || ((state_q == DRAIN) && (outst_q != '0));
    done_o = done_q || ((state_q == DRAIN) && (outst_q == '0));
    err_o  = err_q;
    resp_idx_o = pop ? fifo_idx[rd_ptr_q] : '0;
    resp_cnt_o = pop ? fifo_cnt[rd_ptr_q] : '0;
    resp_off_o = pop ? fifo_off[rd_ptr_q] : '0;
  end

  // Control: outstanding count, tag pointers, start-time pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= start_ok && (vl_i == '0);
      err_q  <= (state_q == IDLE) && start_i && cfg_err;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   outst_q <= outst_q + OUT_W'(1);
        2'b01:   outst_q <= outst_q - OUT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Datapath: configuration latch, element walk, tag storage
  always_ff @(posedge clk_i) begin
    if (start_ok) begin
      cur_q     <= base_addr_i;
      idx_q     <= '0;
      rem_q     <= vl_i;
      sew_q     <= vsew_i;
      strided_q <= strided_i;
      stride_q  <= $signed(stride_i);
    end else if (push) begin
      cur_q <= strided_q ? cur_q + $unsigned(stride_q) : cur_q + ADDR_W'(nbytes);
      idx_q <= idx_q + VL_W'(cnt);
      rem_q <= rem_q - VL_W'(cnt);
    end
    if (push) begin
      fifo_idx[wr_ptr_q] <= idx_q;
      fifo_cnt[wr_ptr_q] <= cnt;
      fifo_off[wr_ptr_q] <= off;
    end
  end

endmodule

// File: tb/tb_vlsu_addr_gen.sv
module tb_vlsu_addr_gen;

  logic        clk = 1'b0;
  logic        rst, start, strided, gnt, rvalid;
  logic [1:0]  sew;
  logic [4:0]  vl;
  logic [31:0] stride, base;
  logic        req, busy, done, err;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [4:0]  r_idx;
  logic [2:0]  r_cnt;
  logic [1:0]  r_off;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vlsu_addr_gen #(.ADDR_W(32), .BUS_BYTES(4), .VL_W(5), .MAX_OUTST(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .vsew_i(sew), .vl_i(vl),
    .strided_i(strided), .stride_i(stride), .base_addr_i(base),
    .data_req_o(req), .data_gnt_i(gnt), .data_addr_o(addr), .data_be_o(be),
    .data_rvalid_i(rvalid), .resp_idx_o(r_idx), .resp_cnt_o(r_cnt),
    .resp_off_o(r_off), .busy_o(busy), .done_o(done), .err_o(err)
  );

  typedef struct {
    string            name;
    logic [1:0]       sew;
    logic [4:0]       vl;
    logic             strided;
    logic [31:0]      stride;
    logic [31:0]      base;
    bit               exp_err;
    int               nbeats;
    logic [7:0][31:0] addr;
    logic [7:0][3:0]  be;
    logic [7:0][4:0]  idx;
    logic [7:0][2:0]  cnt;
    logic [7:0][1:0]  off;
  } vec_t;

  vec_t vecs[12];
  int   nvec = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [1:0] s, input logic [4:0] v,
                         input logic st, input logic [31:0] strd, input logic [31:0] b,
                         input bit e);
    vecs[nvec].name    = name;
    vecs[nvec].sew     = s;
    vecs[nvec].vl      = v;
    vecs[nvec].strided = st;
    vecs[nvec].stride  = strd;
    vecs[nvec].base    = b;
    vecs[nvec].exp_err = e;
    vecs[nvec].nbeats  = 0;
    nvec++;
  endtask

  task automatic beat(input logic [31:0] a, input logic [3:0] b, input logic [4:0] i,
                      input logic [2:0] c, input logic [1:0] o);
    int k;
    int n;
    k = nvec - 1;
    n = vecs[k].nbeats;
    vecs[k].addr[n] = a;
    vecs[k].be[n]   = b;
    vecs[k].idx[n]  = i;
    vecs[k].cnt[n]  = c;
    vecs[k].off[n]  = o;
    vecs[k].nbeats  = n + 1;
  endtask

  task automatic drive_start(input logic [1:0] s, input logic [4:0] v, input logic st,
                             input logic [31:0] strd, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; sew = s; vl = v; strided = st; stride = strd; base = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one transfer with gnt tied high and each response one cycle after its grant.
  task automatic run_vec(input int vi);
    int g, r;
    bit pend, gnow, got_done, got_err;
    g = 0; r = 0; pend = 0; got_done = 0; got_err = 0;
    gnt = 1'b1; rvalid = 1'b0;
    drive_start(vecs[vi].sew, vecs[vi].vl, vecs[vi].strided, vecs[vi].stride, vecs[vi].base);
    for (int cyc = 0; cyc < 60 && !(got_done || got_err); cyc++) begin
      rvalid = pend;
      #1;
      gnow = req;
      if (req) begin
        if (g < vecs[vi].nbeats) begin
          chk({vecs[vi].name, " addr"}, addr, vecs[vi].addr[g]);
          chk({vecs[vi].name, " be"}, 32'(be), 32'(vecs[vi].be[g]));
          chk({vecs[vi].name, " busy"}, 32'(busy), 32'd1);
        end else begin
          chk({vecs[vi].name, " extra beat"}, 32'(g), 32'(vecs[vi].nbeats));
        end
        g++;
      end
      if (rvalid && r < vecs[vi].nbeats) begin
        chk({vecs[vi].name, " resp_idx"}, 32'(r_idx), 32'(vecs[vi].idx[r]));
        chk({vecs[vi].name, " resp_cnt"}, 32'(r_cnt), 32'(vecs[vi].cnt[r]));
        chk({vecs[vi].name, " resp_off"}, 32'(r_off), 32'(vecs[vi].off[r]));
        r++;
      end
      if (done) begin
        got_done = 1;
        chk({vecs[vi].name, " busy at done"}, 32'(busy), 32'd0);
      end
      if (err) got_err = 1;
      pend = gnow;
      @(negedge clk);
    end
    rvalid = 1'b0;
    chk({vecs[vi].name, " err seen"}, 32'(got_err), 32'(vecs[vi].exp_err));
    chk({vecs[vi].name, " done seen"}, 32'(got_done), 32'(!vecs[vi].exp_err));
    chk({vecs[vi].name, " beats issued"}, 32'(g), 32'(vecs[vi].nbeats));
    chk({vecs[vi].name, " beats answered"}, 32'(r), 32'(vecs[vi].nbeats));
    #1;
    chk({vecs[vi].name, " idle after"}, {29'd0, busy, done, err}, 32'd0);
  endtask

  task automatic step(input logic g_in, input logic rv_in);
    @(negedge clk);
    gnt = g_in; rvalid = rv_in;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sew = '0; vl = '0; strided = 1'b0;
    stride = '0; base = '0; gnt = 1'b0; rvalid = 1'b0;

    // Vector table
    add_vec("unit8",      2'd0, 5'd8,  1'b0, 32'd0,        32'h100,      0);
    beat(32'h100, 4'hF, 5'd0, 3'd4, 2'd0);
    beat(32'h104, 4'hF, 5'd4, 3'd4, 2'd0);
    add_vec("unit16mis",  2'd1, 5'd4,  1'b0, 32'd0,        32'h102,      0);
    beat(32'h100, 4'hC, 5'd0, 3'd1, 2'd2);
    beat(32'h104, 4'hF, 5'd1, 3'd2, 2'd0);
    beat(32'h108, 4'h3, 5'd3, 3'd1, 2'd0);
    add_vec("str12",      2'd2, 5'd3,  1'b1, 32'd12,       32'h200,      0);
    beat(32'h200, 4'hF, 5'd0, 3'd1, 2'd0);
    beat(32'h20C, 4'hF, 5'd1, 3'd1, 2'd0);
    beat(32'h218, 4'hF, 5'd2, 3'd1, 2'd0);
    add_vec("strneg",     2'd2, 5'd3,  1'b1, 32'hFFFFFFFC, 32'h8,        0);
    beat(32'h8, 4'hF, 5'd0, 3'd1, 2'd0);
    beat(32'h4, 4'hF, 5'd1, 3'd1, 2'd0);
    beat(32'h0, 4'hF, 5'd2, 3'd1, 2'd0);
    add_vec("unit8mis",   2'd0, 5'd3,  1'b0, 32'd0,        32'h103,      0);
    beat(32'h100, 4'h8, 5'd0, 3'd1, 2'd3);
    beat(32'h104, 4'h3, 5'd1, 3'd2, 2'd0);
    add_vec("str8",       2'd0, 5'd2,  1'b1, 32'd5,        32'h11,       0);
    beat(32'h10, 4'h2, 5'd0, 3'd1, 2'd1);
    beat(32'h14, 4'h4, 5'd1, 3'd1, 2'd2);
    add_vec("wrap",       2'd2, 5'd2,  1'b0, 32'd0,        32'hFFFFFFFC, 0);
    beat(32'hFFFFFFFC, 4'hF, 5'd0, 3'd1, 2'd0);
    beat(32'h0, 4'hF, 5'd1, 3'd1, 2'd0);
    add_vec("vlmax",      2'd0, 5'd31, 1'b0, 32'd0,        32'h1,        0);
    beat(32'h0, 4'hE, 5'd0, 3'd3, 2'd1);
    for (int k = 1; k < 8; k++) beat(32'(4 * k), 4'hF, 5'(4 * k - 1), 3'd4, 2'd0);
    add_vec("vl0",        2'd0, 5'd0,  1'b0, 32'd0,        32'h100,      0);
    add_vec("sew3",       2'd3, 5'd4,  1'b0, 32'd0,        32'h100,      1);
    add_vec("misbase",    2'd1, 5'd4,  1'b0, 32'd0,        32'h101,      1);
    add_vec("misstride",  2'd2, 5'd4,  1'b1, 32'd6,        32'h200,      1);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst req",  32'(req), 32'd0);
    chk("rst busy", {29'd0, busy, done, err}, 32'd0);
    chk("rst addr", addr, 32'd0);
    chk("rst be",   32'(be), 32'd0);
    chk("rst resp", {22'd0, r_idx, r_cnt, r_off}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) run_vec(i);

    // Grant stall, outstanding limit, simultaneous push/pop
    gnt = 1'b0; rvalid = 1'b0;
    drive_start(2'd0, 5'd16, 1'b0, 32'd0, 32'h100);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall req",  32'(req), 32'd1);
      chk("stall addr", addr, 32'h100);
      chk("stall be",   32'(be), 32'hF);
      step(1'b0, 1'b0);
    end
    gnt = 1'b1; #0;
    chk("g1 addr", addr, 32'h100);
    step(1'b1, 1'b0);
    chk("g2 addr", addr, 32'h104);
    chk("g2 req",  32'(req), 32'd1);
    step(1'b1, 1'b0);
    chk("full req", 32'(req), 32'd0);
    step(1'b0, 1'b1);
    chk("full req rv", 32'(req), 32'd0);
    chk("rv0", {22'd0, r_idx, r_cnt, r_off}, {22'd0, 5'd0, 3'd4, 2'd0});
    step(1'b1, 1'b0);
    chk("g3 req",  32'(req), 32'd1);
    chk("g3 addr", addr, 32'h108);
    step(1'b1, 1'b1);
    chk("full2 req", 32'(req), 32'd0);
    chk("rv1", {22'd0, r_idx, r_cnt, r_off}, {22'd0, 5'd4, 3'd4, 2'd0});
    step(1'b1, 1'b1);
    chk("g4 addr", addr, 32'h10C);
    chk("g4 req",  32'(req), 32'd1);
    chk("rv2", {22'd0, r_idx, r_cnt, r_off}, {22'd0, 5'd8, 3'd4, 2'd0});
    step(1'b0, 1'b1);
    chk("drain req", 32'(req), 32'd0);
    chk("drain busy", 32'(busy), 32'd1);
    chk("rv3", {22'd0, r_idx, r_cnt, r_off}, {22'd0, 5'd12, 3'd4, 2'd0});
    step(1'b0, 1'b0);
    chk("stall done", 32'(done), 32'd1);
    chk("stall busy", 32'(busy), 32'd0);
    step(1'b0, 1'b0);
    chk("stall done pulse", 32'(done), 32'd0);

    // Reset in the middle of ISSUE with one beat outstanding
    gnt = 1'b1;
    drive_start(2'd0, 5'd8, 1'b0, 32'd0, 32'h100);
    #1;
    chk("pre-rst req", 32'(req), 32'd1);
    @(negedge clk);
    gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b1;
    #1;
    chk("mid-rst req",  32'(req), 32'd0);
    chk("mid-rst stat", {29'd0, busy, done, err}, 32'd0);
    chk("mid-rst addr", addr, 32'd0);
    chk("mid-rst be",   32'(be), 32'd0);
    chk("mid-rst resp", {22'd0, r_idx, r_cnt, r_off}, 32'd0);
    step(1'b0, 1'b0);
    chk("mid-rst no done", {29'd0, busy, done, err}, 32'd0);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
